tick_task_sequencer: RTL

//  Consumes the periodic tick from the cyclic N-ms delay generator. On each tick it

---
 rtl/tick_task_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/tick_task_sequencer.sv
// Tick-driven task sequencer: on each tick edge, starts the enabled task
// slots one after another, each waiting for done or a timeout.
module tick_task_sequencer #(
  parameter int          NUM_TASK    = 4,
  parameter logic [15:0] TIMEOUT_CYC = 16'd49999,
  parameter int          CNT_W       = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                tick_in,
  input  logic                en,
  input  logic [NUM_TASK-1:0] task_mask,
  input  logic [NUM_TASK-1:0] task_done,
  input  logic                clr_err,
  output logic [NUM_TASK-1:0] task_start,
  output logic                busy,
  output logic                overrun,
  output logic [NUM_TASK-1:0] timeout_err,
  output logic [CNT_W-1:0]    frame_cnt
);

  localparam int IDX_W = (NUM_TASK > 1) ? $clog2(NUM_TASK) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_TASK - 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    NEXT
  } state_t;

  state_t              state, state_nx;
  logic [IDX_W-1:0]    idx, idx_nx;
  logic [15:0]         timer, timer_nx;
  logic                first, first_nx;
  logic                tick_d;
  logic                tick_edge;
  logic [CNT_W-1:0]    fc_nx;
  logic [NUM_TASK-1:0] to_set;
  logic                ov_set;

  assign tick_edge = tick_in & ~tick_d;

  // Next-state logic, error set events and the start pulse.
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    timer_nx   = timer;
    first_nx   = first;
    fc_nx      = frame_cnt;
    to_set     = '0;
    ov_set     = tick_edge & en & (state != IDLE);
    task_start = '0;
    unique case (state)
      IDLE: begin
        if (tick_edge && en) begin
          state_nx = LAUNCH;
          idx_nx   = '0;
          fc_nx    = frame_cnt + CNT_W'(1);
        end
      end
      LAUNCH: begin
        if (task_mask[idx]) begin
          state_nx = WAIT;
          timer_nx = '0;
          first_nx = 1'b1;
        end else begin
          state_nx = NEXT;
        end
      end
      WAIT: begin
        first_nx = 1'b0;
        if (first) task_start[idx] = 1'b1;
        if (!first && task_done[idx]) begin
          state_nx = NEXT;
        end else if (timer == TIMEOUT_CYC) begin
          to_set[idx] = 1'b1;
          state_nx    = NEXT;
        end else begin
          timer_nx = timer + 16'd1;
        end
      end
      NEXT: begin
        if (idx == LAST) begin
          state_nx = IDLE;
        end else begin
          idx_nx   = idx + IDX_W'(1);
          state_nx = LAUNCH;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // State, counters and sticky flags; a set event beats a clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      idx         <= '0;
      timer       <= '0;
      first       <= 1'b0;
      tick_d      <= 1'b1;
      frame_cnt   <= '0;
      overrun     <= 1'b0;
      timeout_err <= '0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      timer       <= timer_nx;
      first       <= first_nx;
      tick_d      <= tick_in;
      frame_cnt   <= fc_nx;
      overrun     <= ov_set | (overrun & ~clr_err);
      timeout_err <= to_set |
                     (timeout_err & ~{NUM_TASK{clr_err}});
    end
  end

endmodule
